// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-stage FSM encoding and default ack timeout.
package cpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one memory request at a time, stalls until ack/timeout, owns MEM/WB.
// Optional MEM_ALIGN_CHK_EN: rejects word accesses with ALUResult_i[1:0] != 0 and pulses align_err_o.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [31:0] instr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] MemData_o,
  output logic [31:0] instr_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        timeout_err_o,
  output logic        align_err_o,
  output mau_state_e  state_o
);

  // Memory handshake: mem_req_o/we/addr/wdata are held stable from issue until the
  // edge on which mem_ack_i is sampled high (transfer completes) or the wait times out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  mau_state_e  state_q, state_d;
  logic        access, misaligned, issue, ack_hit, timeout_hit, stall_d;
  logic [7:0]  wait_cnt_q;
  logic [31:0] lat_pc, lat_valu, lat_instr;
  logic [4:0]  lat_rdaddr;
  logic        lat_regwrite, lat_memtoreg, lat_read;

  assign access = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = access && (ALUResult_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    stall_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          issue   = 1'b1;
          stall_d = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          ack_hit = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          // Release the pipeline so the abandoned instruction is not reissued.
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o = stall_d & start_i;
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      wait_cnt_q    <= '0;
      timeout_err_o <= 1'b0;
      lat_pc        <= '0;
      lat_valu      <= '0;
      lat_instr     <= '0;
      lat_rdaddr    <= '0;
      lat_regwrite  <= 1'b0;
      lat_memtoreg  <= 1'b0;
      lat_read      <= 1'b0;
      pc_o          <= '0;
      ALUResult_o   <= '0;
      VALUResult_o  <= '0;
      MemData_o     <= '0;
      instr_o       <= '0;
      RDaddr_o      <= '0;
      RegWrite_o    <= 1'b0;
      MemToReg_o    <= 1'b0;
    end else begin
      timeout_err_o <= 1'b0;
      if (issue) begin
        mem_req_o    <= 1'b1;
        mem_we_o     <= MemWrite_i;
        mem_addr_o   <= ALUResult_i;
        mem_wdata_o  <= RDData_i;
        wait_cnt_q   <= '0;
        lat_pc       <= pc_i;
        lat_valu     <= VALUResult_i;
        lat_instr    <= instr_i;
        lat_rdaddr   <= RDaddr_i;
        lat_regwrite <= RegWrite_i;
        lat_memtoreg <= MemToReg_i;
        lat_read     <= !MemWrite_i;
        RegWrite_o   <= 1'b0;
        MemToReg_o   <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        if (misaligned) begin
          RegWrite_o <= 1'b0;
          MemToReg_o <= 1'b0;
        end else begin
          pc_o         <= pc_i;
          ALUResult_o  <= ALUResult_i;
          VALUResult_o <= VALUResult_i;
          MemData_o    <= '0;
          instr_o      <= instr_i;
          RDaddr_o     <= RDaddr_i;
          RegWrite_o   <= RegWrite_i;
          MemToReg_o   <= MemToReg_i;
        end
      end else if (ack_hit) begin
        mem_req_o    <= 1'b0;
        mem_we_o     <= 1'b0;
        pc_o         <= lat_pc;
        ALUResult_o  <= mem_addr_o;
        VALUResult_o <= lat_valu;
        MemData_o    <= lat_read ? mem_rdata_i : 32'h0;
        instr_o      <= lat_instr;
        RDaddr_o     <= lat_rdaddr;
        RegWrite_o   <= lat_regwrite;
        MemToReg_o   <= lat_memtoreg;
      end else begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
        RegWrite_o <= 1'b0;
        MemToReg_o <= 1'b0;
        if (timeout_hit) begin
          mem_req_o     <= 1'b0;
          mem_we_o      <= 1'b0;
          timeout_err_o <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) align_err_o <= 1'b0;
    else          align_err_o <= (state_q == ST_IDLE) && misaligned;
  end
`else
  assign align_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (ACK_TIMEOUT=4); align path follows MEM_ALIGN_CHK_EN.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic [31:0] pc_i, ALUResult_i, VALUResult_i, RDData_i, instr_i;
  logic [4:0]  RDaddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_o;
  logic [31:0] pc_o, ALUResult_o, VALUResult_o, MemData_o, instr_o;
  logic [4:0]  RDaddr_o;
  logic        RegWrite_o, MemToReg_o, timeout_err_o, align_err_o;
  mau_state_e  state_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(.ACK_TIMEOUT(4)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .pc_i(pc_i), .ALUResult_i(ALUResult_i), .VALUResult_i(VALUResult_i),
    .RDData_i(RDData_i), .instr_i(instr_i), .RDaddr_i(RDaddr_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .pc_o(pc_o), .ALUResult_o(ALUResult_o),
    .VALUResult_o(VALUResult_o), .MemData_o(MemData_o), .instr_o(instr_o),
    .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .timeout_err_o(timeout_err_o), .align_err_o(align_err_o), .state_o(state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive_nop();
    pc_i = 32'h0; ALUResult_i = 32'h0; VALUResult_i = 32'h0; RDData_i = 32'h0;
    instr_i = 32'h0; RDaddr_i = 5'd0; RegWrite_i = 1'b0; MemToReg_i = 1'b0;
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, input logic rw, input logic m2r,
                             input logic rd_en, input logic wr_en);
    pc_i = pc; ALUResult_i = addr; VALUResult_i = pc ^ 32'h5A5A_0000; RDData_i = wdata;
    instr_i = pc + 32'h1000; RDaddr_i = rd; RegWrite_i = rw; MemToReg_i = m2r;
    MemRead_i = rd_en; MemWrite_i = wr_en;
  endtask

  initial begin
    drive_nop();
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    start_i = 1'b0;
    MemRead_i = 1'b1;
    #3;
    // reset state, with a pending load on the inputs
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_req", mem_req_o, 1'b0);
    chk32("rst_alu", ALUResult_o, 32'h0);
    chk1("rst_regwrite", RegWrite_o, 1'b0);
    chk1("rst_tmo", timeout_err_o, 1'b0);
    chk1("rst_state", state_o == ST_IDLE, 1'b1);
    drive_nop();
    start_i = 1'b1;

    // ALU instruction, latency 1
    step();
    drive_instr(32'h40, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk1("alu_stall", stall_o, 1'b0);
    step();
    chk32("alu_result", ALUResult_o, 32'h10);
    chk32("alu_rd", 32'(RDaddr_o), 32'd5);
    chk1("alu_rw", RegWrite_o, 1'b1);
    chk32("alu_pc", pc_o, 32'h40);
    chk1("alu_req", mem_req_o, 1'b0);

    // load from 0x100, ack three cycles after req
    drive_instr(32'h44, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 chk1("ld_stall_idle", stall_o, 1'b1);
    step();
    chk1("ld_req", mem_req_o, 1'b1);
    chk1("ld_we", mem_we_o, 1'b0);
    chk32("ld_addr", mem_addr_o, 32'h100);
    chk1("ld_stall_w0", stall_o, 1'b1);
    chk1("ld_bubble", RegWrite_o, 1'b0);
    chk1("ld_state", state_o == ST_WAIT, 1'b1);
    ALUResult_i = 32'h300;
    step();
    chk1("ld_stall_w1", stall_o, 1'b1);
    chk32("ld_addr_hold", mem_addr_o, 32'h100);
    step();
    chk1("ld_stall_w2", stall_o, 1'b1);
    step();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    #1 chk1("ld_stall_ack", stall_o, 1'b0);
    step();
    mem_ack_i = 1'b0;
    drive_nop();
    chk32("ld_memdata", MemData_o, 32'hDEADBEEF);
    chk1("ld_m2r", MemToReg_o, 1'b1);
    chk1("ld_rw", RegWrite_o, 1'b1);
    chk32("ld_rd", 32'(RDaddr_o), 32'd7);
    chk32("ld_alu", ALUResult_o, 32'h100);
    chk32("ld_pc", pc_o, 32'h44);
    chk1("ld_req_done", mem_req_o, 1'b0);

    // store with both MemRead and MemWrite set, immediate ack
    drive_instr(32'h48, 32'h200, 32'hCAFE0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk1("st_stall_idle", stall_o, 1'b1);
    step();
    chk1("st_we", mem_we_o, 1'b1);
    chk32("st_wdata", mem_wdata_o, 32'hCAFE0001);
    chk32("st_addr", mem_addr_o, 32'h200);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h11111111;
    #1 chk1("st_stall_ack", stall_o, 1'b0);
    step();
    mem_ack_i = 1'b0;
    drive_nop();
    chk1("st_we_done", mem_we_o, 1'b0);
    chk1("st_req_done", mem_req_o, 1'b0);
    chk1("st_rw", RegWrite_o, 1'b0);
    chk32("st_memdata", MemData_o, 32'h0);

    // ack while idle is ignored
    drive_instr(32'h4C, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    drive_nop();
    chk1("idle_ack_state", state_o == ST_IDLE, 1'b1);
    chk32("idle_ack_alu", ALUResult_o, 32'h20);
    chk1("idle_ack_req", mem_req_o, 1'b0);

    // timeout after four WAIT cycles
    drive_instr(32'h50, 32'h400, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk1("to_req_w0", mem_req_o, 1'b1);
    step();
    step();
    chk1("to_stall_w2", stall_o, 1'b1);
    chk1("to_err_w2", timeout_err_o, 1'b0);
    step();
    chk1("to_stall_w3", stall_o, 1'b0);
    chk1("to_req_w3", mem_req_o, 1'b1);
    step();
    drive_nop();
    #1;
    chk1("to_err", timeout_err_o, 1'b1);
    chk1("to_req_drop", mem_req_o, 1'b0);
    chk1("to_rw", RegWrite_o, 1'b0);
    chk1("to_state", state_o == ST_IDLE, 1'b1);
    chk1("to_stall_after", stall_o, 1'b0);
    step();
    chk1("to_err_pulse", timeout_err_o, 1'b0);

    // reset during the second WAIT cycle
    drive_instr(32'h54, 32'h500, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk1("rw_req_before", mem_req_o, 1'b1);
    start_i = 1'b0;
    #1;
    chk1("rw_req", mem_req_o, 1'b0);
    chk1("rw_stall", stall_o, 1'b0);
    chk1("rw_state", state_o == ST_IDLE, 1'b1);
    drive_nop();
    #1 start_i = 1'b1;
    step();
    chk1("rw_state_after", state_o == ST_IDLE, 1'b1);
    chk1("rw_req_after", mem_req_o, 1'b0);

    // misaligned load from 0x102
    drive_instr(32'h58, 32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef MEM_ALIGN_CHK_EN
    #1 chk1("al_stall", stall_o, 1'b0);
    step();
    drive_nop();
    chk1("al_err", align_err_o, 1'b1);
    chk1("al_req", mem_req_o, 1'b0);
    chk1("al_rw", RegWrite_o, 1'b0);
    step();
    chk1("al_err_pulse", align_err_o, 1'b0);
    chk1("al_req_never", mem_req_o, 1'b0);
`else
    #1 chk1("al_stall", stall_o, 1'b1);
    step();
    chk1("al_err", align_err_o, 1'b0);
    chk1("al_req", mem_req_o, 1'b1);
    chk32("al_addr", mem_addr_o, 32'h102);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h0BADF00D;
    step();
    mem_ack_i = 1'b0;
    drive_nop();
    chk32("al_memdata", MemData_o, 32'h0BADF00D);
    chk1("al_req_done", mem_req_o, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time bound
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
